// File: rtl/md_unit_if.sv
// md_unit_if: operand/control bundle between the EX stage and the multiply/divide unit.
// The master side (EX stage / bench) drives operands and controls; the slave side (md_unit)
// returns Busy and the selected HI/LO read value.
interface md_unit_if;
  logic        Start;
  logic [1:0]  MDOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        HIWrite;
  logic        LOWrite;
  logic        HILOSel;
  logic [31:0] PC;
  logic        Busy;
  logic [31:0] Out;

  modport master (
    output Start, MDOp, A, B, HIWrite, LOWrite, HILOSel, PC,
    input  Busy, Out
  );

  modport slave (
    input  Start, MDOp, A, B, HIWrite, LOWrite, HILOSel, PC,
    output Busy, Out
  );
endinterface

// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit for the EX stage (mult, multu, div, divu, mthi,
// mtlo). The result is computed at Start and parked in pending registers; a down-counter
// models the latency and commits HI/LO when it expires.
// Optional: define MD_UNIT_TRACE_EN to print grf-style trace lines on every HI/LO update.
module md_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic      CLK,
  input  logic      Reset,
  md_unit_if.slave  md
);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e      state_q;
  logic [4:0]  cnt_q;
  logic [31:0] hi_q, lo_q;
  logic [31:0] pend_hi_q, pend_lo_q;
  logic        pend_wr_q;

  logic [63:0] a_sx, b_sx, prod_s, prod_u;
  logic        div_ovf, div_zero;
  logic [31:0] u_div, s_div;
  logic [31:0] res_hi, res_lo;

  assign a_sx   = {{32{md.A[31]}}, md.A};
  assign b_sx   = {{32{md.B[31]}}, md.B};
  assign prod_s = a_sx * b_sx;
  assign prod_u = {32'd0, md.A} * {32'd0, md.B};

  assign div_zero = (md.B == 32'd0);
  assign div_ovf  = (md.A == 32'h8000_0000) && (md.B == 32'hFFFF_FFFF);
  // Substitute divisor 1 for the zero and overflow cases so the divider never sees them.
  assign u_div = div_zero ? 32'd1 : md.B;
  assign s_div = (div_zero || div_ovf) ? 32'd1 : md.B;

  // Result selection for the operation being launched this cycle.
  always_comb begin
    res_hi = 32'd0;
    res_lo = 32'd0;
    unique case (md.MDOp)
      2'b00: begin
        res_hi = prod_s[63:32];
        res_lo = prod_s[31:0];
      end
      2'b01: begin
        res_hi = prod_u[63:32];
        res_lo = prod_u[31:0];
      end
      2'b10: begin
        if (div_ovf) begin
          res_hi = 32'd0;
          res_lo = 32'h8000_0000;
        end else begin
          res_hi = $signed(md.A) % $signed(s_div);
          res_lo = $signed(md.A) / $signed(s_div);
        end
      end
      default: begin
        res_hi = md.A % u_div;
        res_lo = md.A / u_div;
      end
    endcase
  end

`ifdef MD_UNIT_TRACE_EN
  logic [31:0] pc_q;
`else
  logic unused_pc;
  assign unused_pc = ^md.PC;
`endif

  // Control FSM: launch, latency countdown, commit, and idle mthi/mtlo writes.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q   <= StIdle;
      cnt_q     <= 5'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      pend_wr_q <= 1'b0;
`ifdef MD_UNIT_TRACE_EN
      pc_q      <= 32'd0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (md.Start) begin
            // Start wins over a same-cycle mthi/mtlo.
            pend_hi_q <= res_hi;
            pend_lo_q <= res_lo;
            pend_wr_q <= !(md.MDOp[1] && div_zero);
            cnt_q     <= md.MDOp[1] ? 5'(DIV_CYCLES) : 5'(MULT_CYCLES);
            state_q   <= StBusy;
`ifdef MD_UNIT_TRACE_EN
            pc_q      <= md.PC;
`endif
          end else begin
            if (md.HIWrite) begin
              hi_q <= md.A;
`ifdef MD_UNIT_TRACE_EN
              $display("%d@%h: $hi <= %h", $time, md.PC, md.A);
`endif
            end
            if (md.LOWrite) begin
              lo_q <= md.A;
`ifdef MD_UNIT_TRACE_EN
              $display("%d@%h: $lo <= %h", $time, md.PC, md.A);
`endif
            end
          end
        end
        default: begin
          cnt_q <= cnt_q - 5'd1;
          if (cnt_q == 5'd1) begin
            state_q <= StIdle;
            if (pend_wr_q) begin
              hi_q <= pend_hi_q;
              lo_q <= pend_lo_q;
`ifdef MD_UNIT_TRACE_EN
              $display("%d@%h: $hi <= %h", $time, pc_q, pend_hi_q);
              $display("%d@%h: $lo <= %h", $time, pc_q, pend_lo_q);
`endif
            end
          end
        end
      endcase
    end
  end

  assign md.Busy = (state_q == StBusy);
  assign md.Out  = md.HILOSel ? hi_q : lo_q;

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed self-checking bench for md_unit with hand-computed HI/LO values.
module tb_md_unit;

  logic CLK;
  logic Reset;
  int   n_checks;
  int   n_errors;

  md_unit_if bus ();

  md_unit #(
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10)
  ) u_dut (
    .CLK   (CLK),
    .Reset (Reset),
    .md    (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Read HI and LO through the Out mux and compare both.
  task automatic check_hilo(input string tag, input logic [31:0] hi_e, input logic [31:0] lo_e);
    bus.HILOSel = 1'b1;
    #1;
    check({tag, ".hi"}, bus.Out, hi_e);
    bus.HILOSel = 1'b0;
    #1;
    check({tag, ".lo"}, bus.Out, lo_e);
  endtask

  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge CLK);
    bus.Start = 1'b1;
    bus.MDOp  = op;
    bus.A     = a;
    bus.B     = b;
    @(negedge CLK);
    bus.Start = 1'b0;
  endtask

  task automatic write_hilo(input logic hw, input logic lw, input logic [31:0] a);
    @(negedge CLK);
    bus.HIWrite = hw;
    bus.LOWrite = lw;
    bus.A       = a;
    @(negedge CLK);
    bus.HIWrite = 1'b0;
    bus.LOWrite = 1'b0;
  endtask

  // Counts negedges on which Busy is seen high; bounded at 40.
  task automatic wait_done(output int cycles);
    cycles = 0;
    while (bus.Busy && cycles < 40) begin
      @(negedge CLK);
      cycles++;
    end
  endtask

  initial begin
    int cyc;
    int extra;
    n_checks    = 0;
    n_errors    = 0;
    Reset       = 1'b1;
    bus.Start   = 1'b0;
    bus.MDOp    = 2'b00;
    bus.A       = 32'd0;
    bus.B       = 32'd0;
    bus.HIWrite = 1'b0;
    bus.LOWrite = 1'b0;
    bus.HILOSel = 1'b0;
    bus.PC      = 32'h0000_3000;
    repeat (2) @(negedge CLK);
    Reset = 1'b0;
    check("reset.busy", {31'd0, bus.Busy}, 32'd0);
    check_hilo("reset", 32'd0, 32'd0);

    // Signed multiply: -2 * 3 = -6.
    start_op(2'b00, 32'hFFFF_FFFE, 32'd3);
    check("mult.busy_start", {31'd0, bus.Busy}, 32'd1);
    check_hilo("mult.old", 32'd0, 32'd0);
    wait_done(cyc);
    check("mult.lat", cyc, 32'd5);
    check_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);

    // Unsigned multiply with an ignored second Start at busy cycle 2.
    start_op(2'b01, 32'hFFFF_FFFF, 32'd2);
    @(negedge CLK);
    bus.Start = 1'b1;
    bus.MDOp  = 2'b00;
    bus.A     = 32'd1;
    bus.B     = 32'd1;
    @(negedge CLK);
    bus.Start = 1'b0;
    wait_done(cyc);
    check("multu.lat", cyc + 2, 32'd5);
    check_hilo("multu", 32'd1, 32'hFFFF_FFFE);
    @(negedge CLK);
    check("multu.no_restart", {31'd0, bus.Busy}, 32'd0);

    // Signed divide -7 / 2; Out holds the old LO for every busy cycle.
    start_op(2'b10, 32'hFFFF_FFF9, 32'd2);
    cyc   = 0;
    extra = 0;
    bus.HILOSel = 1'b0;
    while (bus.Busy && cyc < 40) begin
      #1;
      if (bus.Out !== 32'hFFFF_FFFE) extra++;
      @(negedge CLK);
      cyc++;
    end
    check("div.lat", cyc, 32'd10);
    check("div.old_held", extra, 32'd0);
    check_hilo("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    // Idle writes: both together, then separately.
    write_hilo(1'b1, 1'b1, 32'hCAFE_F00D);
    check_hilo("mthilo_both", 32'hCAFE_F00D, 32'hCAFE_F00D);
    write_hilo(1'b1, 1'b0, 32'h1234_5678);
    write_hilo(1'b0, 1'b1, 32'h9ABC_DEF0);
    check_hilo("mthi_mtlo", 32'h1234_5678, 32'h9ABC_DEF0);

    // Divide by zero: full latency, HI/LO untouched.
    start_op(2'b11, 32'd7, 32'd0);
    wait_done(cyc);
    check("divu0.lat", cyc, 32'd10);
    check_hilo("divu0", 32'h1234_5678, 32'h9ABC_DEF0);
    start_op(2'b10, 32'd7, 32'd0);
    wait_done(cyc);
    check_hilo("div0", 32'h1234_5678, 32'h9ABC_DEF0);

    // Signed overflow, unsigned divide, negative divisor.
    start_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(cyc);
    check_hilo("div_ovf", 32'd0, 32'h8000_0000);
    start_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(cyc);
    check_hilo("divu_big", 32'h8000_0000, 32'd0);
    start_op(2'b11, 32'd100, 32'd7);
    wait_done(cyc);
    check_hilo("divu", 32'd2, 32'd14);
    start_op(2'b10, 32'd7, 32'hFFFF_FFFE);
    wait_done(cyc);
    check_hilo("div_negb", 32'd1, 32'hFFFF_FFFD);

    // Reset at busy cycle 3 of mult 5*5.
    start_op(2'b00, 32'd5, 32'd5);
    repeat (2) @(negedge CLK);
    check("rst_mid.busy_before", {31'd0, bus.Busy}, 32'd1);
    Reset = 1'b1;
    @(negedge CLK);
    Reset = 1'b0;
    check("rst_mid.busy", {31'd0, bus.Busy}, 32'd0);
    check_hilo("rst_mid", 32'd0, 32'd0);
    repeat (8) @(negedge CLK);
    check("rst_mid.later_busy", {31'd0, bus.Busy}, 32'd0);
    check_hilo("rst_mid.later", 32'd0, 32'd0);

    // mthi in the Start cycle is dropped.
    @(negedge CLK);
    bus.Start   = 1'b1;
    bus.MDOp    = 2'b01;
    bus.A       = 32'h11;
    bus.B       = 32'h2;
    bus.HIWrite = 1'b1;
    @(negedge CLK);
    bus.Start   = 1'b0;
    bus.HIWrite = 1'b0;
    wait_done(cyc);
    check_hilo("conflict", 32'd0, 32'h22);

    // mthi / mtlo while busy are dropped.
    start_op(2'b00, 32'd3, 32'd3);
    bus.HIWrite = 1'b1;
    bus.LOWrite = 1'b1;
    bus.A       = 32'h0000_DEAD;
    @(negedge CLK);
    bus.HIWrite = 1'b0;
    bus.LOWrite = 1'b0;
    wait_done(cyc);
    check("busy_wr.lat", cyc + 1, 32'd5);
    check_hilo("busy_wr", 32'd0, 32'd9);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
